// File: rtl/max_n10_feeder_pkg.sv
// Shared constants and helpers for the 10-lane window feeder.
// Provides lane count, counter widths, control phases and a stride check.
package max_n10_feeder_pkg;

    localparam int N_LANES  = 10;
    localparam int FILL_W   = 4;
    localparam int STRIDE_W = 4;

    // FILL: collecting the first window of a frame.
    // STREAM: first window out, emitting every STRIDE samples.
    typedef enum logic [0:0] {
        PH_FILL   = 1'b0,
        PH_STREAM = 1'b1
    } phase_t;

    // A window stride is legal when it advances at least one sample
    // and never skips samples between windows.
    function automatic bit stride_ok(input int stride, input int lanes);
        return (stride >= 1) && (stride <= lanes);
    endfunction

endpackage

// File: rtl/max_n10_feeder_ctrl.sv
// Window control: fill/stride counting, enable pulse and window index.
// Ports: clk, rst_n, vld, sof in; den, win_idx out (both registered).
module max_n10_feeder_ctrl
    import max_n10_feeder_pkg::*;
#(
    parameter int STRIDE    = 10,
    parameter int WIN_IDX_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 vld,
    input  logic                 sof,
    output logic                 den,
    output logic [WIN_IDX_W-1:0] win_idx
);

    localparam logic [FILL_W-1:0]   FILL_LAST = FILL_W'(N_LANES - 1);
    localparam logic [FILL_W-1:0]   FILL_FULL = FILL_W'(N_LANES);
    localparam logic [STRIDE_W-1:0] STR_LAST  = STRIDE_W'(STRIDE - 1);

    phase_t              phase;
    phase_t              phase_nxt;
    logic [FILL_W-1:0]   fill_cnt;
    logic [FILL_W-1:0]   fill_nxt;
    logic [STRIDE_W-1:0] stride_cnt;
    logic [STRIDE_W-1:0] stride_nxt;
    logic                emit;
    logic                restart;

    assign restart = vld & sof;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase      <= PH_FILL;
            fill_cnt   <= '0;
            stride_cnt <= '0;
        end else begin
            phase      <= phase_nxt;
            fill_cnt   <= fill_nxt;
            stride_cnt <= stride_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        phase_nxt  = phase;
        fill_nxt   = fill_cnt;
        stride_nxt = stride_cnt;
        if (restart) begin
            phase_nxt  = PH_FILL;
            fill_nxt   = FILL_W'(1);
            stride_nxt = '0;
        end else if (vld) begin
            if (fill_cnt != FILL_FULL) begin
                fill_nxt = fill_cnt + FILL_W'(1);
            end
            unique case (phase)
                PH_FILL: begin
                    if (emit) begin
                        phase_nxt  = PH_STREAM;
                        stride_nxt = '0;
                    end
                end
                PH_STREAM: begin
                    if (emit) begin
                        stride_nxt = '0;
                    end else begin
                        stride_nxt = stride_cnt + STRIDE_W'(1);
                    end
                end
                default: phase_nxt = PH_FILL;
            endcase
        end
    end

    // Output logic: a restarting sample never completes a window.
    always_comb begin
        emit = 1'b0;
        if (vld && !sof) begin
            unique case (phase)
                PH_FILL:   emit = (fill_cnt == FILL_LAST);
                PH_STREAM: emit = (stride_cnt == STR_LAST);
                default:   emit = 1'b0;
            endcase
        end
    end

    // den is high in the cycle after the emitting sample; win_idx
    // advances on the edge that ends that cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            den     <= 1'b0;
            win_idx <= '0;
        end else begin
            den <= emit;
            if (restart) begin
                win_idx <= '0;
            end else if (den) begin
                win_idx <= win_idx + WIN_IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/max_n10_feeder.sv
// Serial-to-window feeder for the 10-input max stage.
// Ports: clk, rst_n, din_vld, din, sof in; den_out, data_out0..9, win_idx out.
module max_n10_feeder
    import max_n10_feeder_pkg::*;
#(
    parameter int BW        = 8,
    parameter int STRIDE    = 10,
    parameter int WIN_IDX_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 din_vld,
    input  logic [BW-1:0]        din,
    input  logic                 sof,
    output logic                 den_out,
    output logic [BW-1:0]        data_out0,
    output logic [BW-1:0]        data_out1,
    output logic [BW-1:0]        data_out2,
    output logic [BW-1:0]        data_out3,
    output logic [BW-1:0]        data_out4,
    output logic [BW-1:0]        data_out5,
    output logic [BW-1:0]        data_out6,
    output logic [BW-1:0]        data_out7,
    output logic [BW-1:0]        data_out8,
    output logic [BW-1:0]        data_out9,
    output logic [WIN_IDX_W-1:0] win_idx
);

    if (!stride_ok(STRIDE, N_LANES)) begin : g_bad_stride
        $error("max_n10_feeder: STRIDE must be 1..10");
    end

    logic [BW-1:0] lane [N_LANES];

    // Lane 0 holds the oldest sample; a frame start zeroes the history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_LANES; i++) begin
                lane[i] <= '0;
            end
        end else if (din_vld) begin
            for (int i = 0; i < N_LANES - 1; i++) begin
                lane[i] <= sof ? '0 : lane[i+1];
            end
            lane[N_LANES-1] <= din;
        end
    end

    max_n10_feeder_ctrl #(
        .STRIDE    (STRIDE),
        .WIN_IDX_W (WIN_IDX_W)
    ) u_ctrl (
        .clk     (clk),
        .rst_n   (rst_n),
        .vld     (din_vld),
        .sof     (sof),
        .den     (den_out),
        .win_idx (win_idx)
    );

    assign data_out0 = lane[0];
    assign data_out1 = lane[1];
    assign data_out2 = lane[2];
    assign data_out3 = lane[3];
    assign data_out4 = lane[4];
    assign data_out5 = lane[5];
    assign data_out6 = lane[6];
    assign data_out7 = lane[7];
    assign data_out8 = lane[8];
    assign data_out9 = lane[9];

endmodule

// File: tb/tb_max_n10_feeder.sv
// Bench for max_n10_feeder: three instances (STRIDE 10, 1, 3) on one stream.
// Expected windows come from a frame-history model and are queued per instance.
module tb_max_n10_feeder;

    typedef struct packed {
        logic [31:0] cyc;
        logic [15:0] idx;
        logic [79:0] l;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       din_vld;
    logic [7:0] din;
    logic       sof;

    logic [7:0]  lanes [3][10];
    logic [15:0] widx  [3];
    logic        dens  [3];

    int strd [3] = '{10, 1, 3};
    int wmsk [3] = '{32'hffff, 32'h3, 32'hffff};

    exp_t q [3][$];
    logic [7:0] hist [$];
    int n;
    int cyc;
    int total;
    int bad;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int S = (g == 0) ? 10 : (g == 1) ? 1 : 3;
        localparam int W = (g == 1) ? 2 : 16;
        logic [W-1:0] wi;
        logic         de;
        max_n10_feeder #(
            .BW        (8),
            .STRIDE    (S),
            .WIN_IDX_W (W)
        ) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .din_vld   (din_vld),
            .din       (din),
            .sof       (sof),
            .den_out   (de),
            .data_out0 (lanes[g][0]),
            .data_out1 (lanes[g][1]),
            .data_out2 (lanes[g][2]),
            .data_out3 (lanes[g][3]),
            .data_out4 (lanes[g][4]),
            .data_out5 (lanes[g][5]),
            .data_out6 (lanes[g][6]),
            .data_out7 (lanes[g][7]),
            .data_out8 (lanes[g][8]),
            .data_out9 (lanes[g][9]),
            .win_idx   (wi)
        );
        assign widx[g] = 16'(wi);
        assign dens[g] = de;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Output monitor: den must match the queue head's due cycle.
    always @(posedge clk) begin
        #1;
        cyc++;
        for (int g = 0; g < 3; g++) begin
            logic due;
            exp_t e;
            due = (q[g].size() > 0) && (q[g][0].cyc == cyc);
            chk($sformatf("den%0d", g), 32'(dens[g]), 32'(due));
            if (due) begin
                e = q[g].pop_front();
                chk($sformatf("idx%0d", g), 32'(widx[g]), 32'(e.idx));
                for (int k = 0; k < 10; k++) begin
                    chk($sformatf("lane%0d_%0d", g, k),
                        32'(lanes[g][k]), 32'(e.l[8*k +: 8]));
                end
            end
        end
    end

    task automatic model_reset();
        hist.delete();
        n = 0;
        for (int g = 0; g < 3; g++) q[g].delete();
    endtask

    task automatic send(input logic [7:0] d, input logic s);
        exp_t e;
        @(negedge clk);
        din_vld = 1'b1;
        din     = d;
        sof     = s;
        if (s) begin
            hist.delete();
            n = 0;
        end
        hist.push_back(d);
        if (hist.size() > 10) void'(hist.pop_front());
        n++;
        for (int g = 0; g < 3; g++) begin
            if (n == 10 || (n > 10 && (n - 10) % strd[g] == 0)) begin
                e.cyc = 32'(cyc + 1);
                e.idx = 16'(((n - 10) / strd[g]) & wmsk[g]);
                for (int k = 0; k < 10; k++) e.l[8*k +: 8] = hist[k];
                q[g].push_back(e);
            end
        end
    endtask

    task automatic idle(input int cnt, input logic s);
        for (int i = 0; i < cnt; i++) begin
            @(negedge clk);
            din_vld = 1'b0;
            din     = 8'($urandom);
            sof     = s;
        end
    endtask

    task automatic chk_reset_state(input string tag);
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("%s_den%0d", tag, g), 32'(dens[g]), 0);
            chk($sformatf("%s_idx%0d", tag, g), 32'(widx[g]), 0);
            for (int k = 0; k < 10; k++) begin
                chk($sformatf("%s_lane%0d_%0d", tag, g, k),
                    32'(lanes[g][k]), 0);
            end
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        cyc     = 0;
        n       = 0;
        rst_n   = 1'b0;
        din_vld = 1'b0;
        din     = '0;
        sof     = 1'b0;
        #3;
        chk_reset_state("rst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Non-overlapping frame, also wraps the 2-bit index at STRIDE 1.
        for (int i = 1; i <= 20; i++) send(8'(i), i == 1);
        idle(3, 1'b0);

        // Fully sliding.
        for (int i = 1; i <= 12; i++) send(8'(i), i == 1);
        idle(3, 1'b0);

        // Gapped input; sof during idle must be ignored.
        for (int i = 1; i <= 16; i++) begin
            send(8'(i), i == 1);
            idle(2, 1'b1);
        end

        // Restart part-way through the first window.
        for (int i = 1; i <= 5; i++) send(8'(i), i == 1);
        for (int i = 6; i <= 15; i++) send(8'(i), i == 6);
        idle(2, 1'b0);

        // Restart on what would be the 10th sample.
        for (int i = 1; i <= 9; i++) send(8'(i), i == 1);
        for (int i = 10; i <= 19; i++) send(8'(i), i == 10);
        idle(2, 1'b0);

        // Asynchronous reset in the middle of a window.
        for (int i = 1; i <= 7; i++) send(8'(40 + i), i == 1);
        @(negedge clk);
        din_vld = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk_reset_state("arst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) send(8'(30 + i), 1'b0);
        idle(2, 1'b0);

        // Random traffic with sporadic frame starts and gaps.
        for (int i = 0; i < 120; i++) begin
            send(8'($urandom), $urandom_range(0, 11) == 0);
            if ($urandom_range(0, 2) == 0) begin
                idle($urandom_range(1, 2), 1'($urandom));
            end
        end
        idle(4, 1'b0);

        for (int g = 0; g < 3; g++) begin
            chk($sformatf("drain%0d", g), 32'(q[g].size()), 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
